// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, requester ids and the write command carried to the register file
package regfile_pkg;
    localparam int NUM_REG = 8;
    localparam int REG_W   = 3;
    localparam int DATA_W  = 16;
    typedef enum logic {REQ_ALU = 1'b0, REQ_MEM = 1'b1} req_id_t;
    typedef struct packed {
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] data;
        logic              carry_we;
        logic              carry;
        logic              borrow_we;
        logic              borrow;
    } wr_cmd_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: producer handshakes, decode hazard lookups and register-file write strobes
interface regfile_write_arbiter_if;
    import regfile_pkg::*;
    logic               alu_valid_pi;
    logic               alu_ready_po;
    logic [REG_W-1:0]   alu_reg_pi;
    logic [DATA_W-1:0]  alu_data_pi;
    logic               alu_carry_we_pi;
    logic               alu_carry_pi;
    logic               alu_borrow_we_pi;
    logic               alu_borrow_pi;
    logic               mem_valid_pi;
    logic               mem_ready_po;
    logic [REG_W-1:0]   mem_reg_pi;
    logic [DATA_W-1:0]  mem_data_pi;
    logic               reserve_valid_pi;
    logic [REG_W-1:0]   reserve_reg_pi;
    logic [REG_W-1:0]   source_reg1_pi;
    logic [REG_W-1:0]   source_reg2_pi;
    logic               src1_busy_po;
    logic               src2_busy_po;
    logic               wr_en_po;
    logic [REG_W-1:0]   wr_reg_po;
    logic [DATA_W-1:0]  wr_data_po;
    logic               carry_we_po;
    logic               carry_po;
    logic               borrow_we_po;
    logic               borrow_po;
    logic [NUM_REG-1:0] pending_po;
    modport slave (
        input  alu_valid_pi, alu_reg_pi, alu_data_pi, alu_carry_we_pi, alu_carry_pi,
               alu_borrow_we_pi, alu_borrow_pi, mem_valid_pi, mem_reg_pi, mem_data_pi,
               reserve_valid_pi, reserve_reg_pi, source_reg1_pi, source_reg2_pi,
        output alu_ready_po, mem_ready_po, src1_busy_po, src2_busy_po, wr_en_po, wr_reg_po,
               wr_data_po, carry_we_po, carry_po, borrow_we_po, borrow_po, pending_po
    );
    modport master (
        output alu_valid_pi, alu_reg_pi, alu_data_pi, alu_carry_we_pi, alu_carry_pi,
               alu_borrow_we_pi, alu_borrow_pi, mem_valid_pi, mem_reg_pi, mem_data_pi,
               reserve_valid_pi, reserve_reg_pi, source_reg1_pi, source_reg2_pi,
        input  alu_ready_po, mem_ready_po, src1_busy_po, src2_busy_po, wr_en_po, wr_reg_po,
               wr_data_po, carry_we_po, carry_po, borrow_we_po, borrow_po, pending_po
    );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; bit 0 is the ALU, bit 1 the load path
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk_pi,
    input  logic       reset_n_pi,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    req_id_t last_grant;
    assign gnt[0] = req[0] && (!req[1] || last_grant == REQ_MEM);
    assign gnt[1] = req[1] && (!req[0] || last_grant == REQ_ALU);
    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) last_grant <= REQ_MEM;
        else if (advance) last_grant <= gnt[1] ? REQ_MEM : REQ_ALU;
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port and flag update between ALU and loads,
// and tracks per-register pending writes for decode RAW stalls
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic clk_pi,
    input  logic reset_n_pi,
    regfile_write_arbiter_if.slave bus
);
    logic [1:0]         gnt;
    logic               xfer;
    wr_cmd_t            alu_cmd, mem_cmd, cmd_d, cmd_q;
    logic               wr_en_q;
    logic [NUM_REG-1:0] pending_q, pending_d, set_mask, clr_mask;
    rr_arbiter2 u_arb (
        .clk_pi     (clk_pi),
        .reset_n_pi (reset_n_pi),
        .req        ({bus.mem_valid_pi, bus.alu_valid_pi}),
        .advance    (xfer),
        .gnt        (gnt)
    );
    assign bus.alu_ready_po = gnt[0];
    assign bus.mem_ready_po = gnt[1];
    assign xfer = |gnt;
    assign alu_cmd = '{dst: bus.alu_reg_pi, data: bus.alu_data_pi,
                       carry_we: bus.alu_carry_we_pi, carry: bus.alu_carry_pi,
                       borrow_we: bus.alu_borrow_we_pi, borrow: bus.alu_borrow_pi};
    assign mem_cmd = '{dst: bus.mem_reg_pi, data: bus.mem_data_pi,
                       carry_we: 1'b0, carry: 1'b0, borrow_we: 1'b0, borrow: 1'b0};
    // Set beats clear: a reserve in the same cycle belongs to a newer writer still in flight
    always_comb begin
        cmd_d     = gnt[0] ? alu_cmd : gnt[1] ? mem_cmd : '0;
        set_mask  = bus.reserve_valid_pi ? NUM_REG'(1) << bus.reserve_reg_pi : '0;
        clr_mask  = xfer ? NUM_REG'(1) << cmd_d.dst : '0;
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end
    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            wr_en_q   <= 1'b0;
            cmd_q     <= '0;
            pending_q <= '0;
        end else begin
            wr_en_q   <= xfer;
            cmd_q     <= cmd_d;
            pending_q <= pending_d;
        end
    end
    assign bus.wr_en_po     = wr_en_q;
    assign bus.wr_reg_po    = cmd_q.dst;
    assign bus.wr_data_po   = cmd_q.data;
    assign bus.carry_we_po  = cmd_q.carry_we;
    assign bus.carry_po     = cmd_q.carry;
    assign bus.borrow_we_po = cmd_q.borrow_we;
    assign bus.borrow_po    = cmd_q.borrow;
    assign bus.pending_po   = pending_q;
    assign bus.src1_busy_po = pending_q[bus.source_reg1_pi];
    assign bus.src2_busy_po = pending_q[bus.source_reg2_pi];
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenario tasks with hand-computed expectations
module tb_regfile_write_arbiter;
    import regfile_pkg::*;
    logic clk;
    logic reset_n;
    int   tests;
    int   fails;
    regfile_write_arbiter_if bus ();
    regfile_write_arbiter dut (.clk_pi(clk), .reset_n_pi(reset_n), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.alu_valid_pi     = 1'b0;
        bus.alu_reg_pi       = '0;
        bus.alu_data_pi      = '0;
        bus.alu_carry_we_pi  = 1'b0;
        bus.alu_carry_pi     = 1'b0;
        bus.alu_borrow_we_pi = 1'b0;
        bus.alu_borrow_pi    = 1'b0;
        bus.mem_valid_pi     = 1'b0;
        bus.mem_reg_pi       = '0;
        bus.mem_data_pi      = '0;
        bus.reserve_valid_pi = 1'b0;
        bus.reserve_reg_pi   = '0;
        bus.source_reg1_pi   = '0;
        bus.source_reg2_pi   = '0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (bus.wr_en_po !== 1'b0 || bus.wr_reg_po !== 3'd0 || bus.wr_data_po !== 16'h0) begin
            fails++;
            $display("FAIL reset_wr: en=%b reg=%0d data=%h required 0/0/0000", bus.wr_en_po, bus.wr_reg_po, bus.wr_data_po);
        end
        tests++;
        if ({bus.carry_we_po, bus.carry_po, bus.borrow_we_po, bus.borrow_po} !== 4'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b required 0000", {bus.carry_we_po, bus.carry_po, bus.borrow_we_po, bus.borrow_po});
        end
        tests++;
        if (bus.pending_po !== 8'h00) begin
            fails++;
            $display("FAIL reset_pending: got %b required 00000000", bus.pending_po);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (bus.wr_en_po !== 1'b0 || bus.alu_ready_po !== 1'b0 || bus.mem_ready_po !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: en=%b alu_rdy=%b mem_rdy=%b required 0/0/0", bus.wr_en_po, bus.alu_ready_po, bus.mem_ready_po);
        end
    endtask

    task automatic test_alu_write();
        bus.alu_valid_pi    = 1'b1;
        bus.alu_reg_pi      = 3'd3;
        bus.alu_data_pi     = 16'h00A5;
        bus.alu_carry_we_pi = 1'b1;
        bus.alu_carry_pi    = 1'b1;
        #1;
        tests++;
        if (bus.alu_ready_po !== 1'b1 || bus.mem_ready_po !== 1'b0) begin
            fails++;
            $display("FAIL alu_ready: alu=%b mem=%b required 1/0", bus.alu_ready_po, bus.mem_ready_po);
        end
        @(posedge clk);
        #1 idle();
        tests++;
        if (bus.wr_en_po !== 1'b1 || bus.wr_reg_po !== 3'd3 || bus.wr_data_po !== 16'h00A5) begin
            fails++;
            $display("FAIL alu_write: en=%b reg=%0d data=%h required 1/3/00a5", bus.wr_en_po, bus.wr_reg_po, bus.wr_data_po);
        end
        tests++;
        if ({bus.carry_we_po, bus.carry_po, bus.borrow_we_po} !== 3'b110) begin
            fails++;
            $display("FAIL alu_flags: cwe/c/bwe=%b required 110", {bus.carry_we_po, bus.carry_po, bus.borrow_we_po});
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.wr_en_po !== 1'b0 || bus.carry_we_po !== 1'b0) begin
            fails++;
            $display("FAIL alu_single_pulse: en=%b cwe=%b required 0/0", bus.wr_en_po, bus.carry_we_po);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.alu_valid_pi = 1'b1;
        bus.alu_reg_pi   = 3'd1;
        bus.alu_data_pi  = 16'h1111;
        bus.mem_valid_pi = 1'b1;
        bus.mem_reg_pi   = 3'd2;
        bus.mem_data_pi  = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (bus.alu_ready_po !== (i % 2 == 0) || bus.mem_ready_po !== (i % 2 == 1)) begin
                fails++;
                $display("FAIL rr_grant[%0d]: alu=%b mem=%b required %b/%b", i, bus.alu_ready_po, bus.mem_ready_po, i % 2 == 0, i % 2 == 1);
            end
            @(posedge clk);
            #1;
            tests++;
            if (bus.wr_en_po !== 1'b1 || bus.wr_reg_po !== ((i % 2 == 0) ? 3'd1 : 3'd2) ||
                bus.wr_data_po !== ((i % 2 == 0) ? 16'h1111 : 16'h2222)) begin
                fails++;
                $display("FAIL rr_write[%0d]: en=%b reg=%0d data=%h required 1/%0d/%h", i, bus.wr_en_po, bus.wr_reg_po, bus.wr_data_po,
                         (i % 2 == 0) ? 1 : 2, (i % 2 == 0) ? 16'h1111 : 16'h2222);
            end
        end
        idle();
    endtask

    task automatic test_scoreboard();
        bus.reserve_valid_pi = 1'b1;
        bus.reserve_reg_pi   = 3'd5;
        @(posedge clk);
        #1;
        bus.reserve_valid_pi = 1'b0;
        bus.source_reg1_pi   = 3'd5;
        bus.source_reg2_pi   = 3'd4;
        #1;
        tests++;
        if (bus.src1_busy_po !== 1'b1 || bus.src2_busy_po !== 1'b0 || bus.pending_po !== 8'b0010_0000) begin
            fails++;
            $display("FAIL sb_reserve: b1=%b b2=%b pend=%b required 1/0/00100000", bus.src1_busy_po, bus.src2_busy_po, bus.pending_po);
        end
        bus.mem_valid_pi = 1'b1;
        bus.mem_reg_pi   = 3'd5;
        bus.mem_data_pi  = 16'h5555;
        #1;
        tests++;
        if (bus.mem_ready_po !== 1'b1 || bus.src1_busy_po !== 1'b1) begin
            fails++;
            $display("FAIL sb_no_bypass: mem_rdy=%b b1=%b required 1/1", bus.mem_ready_po, bus.src1_busy_po);
        end
        @(posedge clk);
        #1;
        bus.mem_valid_pi = 1'b0;
        tests++;
        if (bus.wr_en_po !== 1'b1 || bus.wr_reg_po !== 3'd5 || bus.src1_busy_po !== 1'b0 || bus.pending_po !== 8'h00) begin
            fails++;
            $display("FAIL sb_clear: en=%b reg=%0d b1=%b pend=%b required 1/5/0/00000000", bus.wr_en_po, bus.wr_reg_po, bus.src1_busy_po, bus.pending_po);
        end
        idle();
    endtask

    task automatic test_set_wins();
        bus.reserve_valid_pi = 1'b1;
        bus.reserve_reg_pi   = 3'd5;
        @(posedge clk);
        #1;
        bus.alu_valid_pi = 1'b1;
        bus.alu_reg_pi   = 3'd5;
        bus.alu_data_pi  = 16'hBEEF;
        @(posedge clk);
        #1;
        idle();
        tests++;
        if (bus.wr_en_po !== 1'b1 || bus.wr_data_po !== 16'hBEEF || bus.pending_po !== 8'b0010_0000) begin
            fails++;
            $display("FAIL set_wins: en=%b data=%h pend=%b required 1/beef/00100000", bus.wr_en_po, bus.wr_data_po, bus.pending_po);
        end
        bus.mem_valid_pi = 1'b1;
        bus.mem_reg_pi   = 3'd5;
        @(posedge clk);
        #1;
        idle();
        tests++;
        if (bus.pending_po !== 8'h00) begin
            fails++;
            $display("FAIL single_clear: pend=%b required 00000000", bus.pending_po);
        end
    endtask

    task automatic test_load_only();
        bus.mem_valid_pi = 1'b1;
        bus.mem_reg_pi   = 3'd7;
        bus.mem_data_pi  = 16'hFFFF;
        #1;
        tests++;
        if (bus.mem_ready_po !== 1'b1 || bus.alu_ready_po !== 1'b0) begin
            fails++;
            $display("FAIL load_ready: mem=%b alu=%b required 1/0", bus.mem_ready_po, bus.alu_ready_po);
        end
        @(posedge clk);
        #1;
        idle();
        tests++;
        if (bus.wr_en_po !== 1'b1 || bus.wr_reg_po !== 3'd7 || bus.wr_data_po !== 16'hFFFF ||
            {bus.carry_we_po, bus.carry_po, bus.borrow_we_po, bus.borrow_po} !== 4'b0 || bus.pending_po !== 8'h00) begin
            fails++;
            $display("FAIL load_write: en=%b reg=%0d data=%h flags=%b pend=%b required 1/7/ffff/0000/00000000", bus.wr_en_po, bus.wr_reg_po,
                     bus.wr_data_po, {bus.carry_we_po, bus.carry_po, bus.borrow_we_po, bus.borrow_po}, bus.pending_po);
        end
    endtask

    task automatic test_alu_borrow();
        bus.alu_valid_pi     = 1'b1;
        bus.alu_reg_pi       = 3'd0;
        bus.alu_data_pi      = 16'h0F0F;
        bus.alu_carry_pi     = 1'b1;
        bus.alu_borrow_we_pi = 1'b1;
        bus.alu_borrow_pi    = 1'b1;
        @(posedge clk);
        #1;
        idle();
        tests++;
        if ({bus.carry_we_po, bus.carry_po, bus.borrow_we_po, bus.borrow_po} !== 4'b0111 || bus.wr_data_po !== 16'h0F0F) begin
            fails++;
            $display("FAIL alu_borrow: flags=%b data=%h required 0111/0f0f", {bus.carry_we_po, bus.carry_po, bus.borrow_we_po, bus.borrow_po}, bus.wr_data_po);
        end
    endtask

    task automatic test_reset_mid();
        bus.alu_valid_pi     = 1'b1;
        bus.alu_reg_pi       = 3'd6;
        bus.alu_data_pi      = 16'h6666;
        bus.reserve_valid_pi = 1'b1;
        bus.reserve_reg_pi   = 3'd6;
        @(posedge clk);
        #1;
        idle();
        tests++;
        if (bus.wr_en_po !== 1'b1 || bus.pending_po !== 8'b0100_0000) begin
            fails++;
            $display("FAIL mid_pre: en=%b pend=%b required 1/01000000", bus.wr_en_po, bus.pending_po);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if (bus.wr_en_po !== 1'b0 || bus.wr_data_po !== 16'h0 || bus.pending_po !== 8'h00) begin
            fails++;
            $display("FAIL mid_async_reset: en=%b data=%h pend=%b required 0/0000/00000000", bus.wr_en_po, bus.wr_data_po, bus.pending_po);
        end
        #1 reset_n = 1'b1;
        bus.alu_valid_pi = 1'b1;
        bus.mem_valid_pi = 1'b1;
        #1;
        tests++;
        if (bus.alu_ready_po !== 1'b1 || bus.mem_ready_po !== 1'b0) begin
            fails++;
            $display("FAIL mid_tie: alu=%b mem=%b required 1/0", bus.alu_ready_po, bus.mem_ready_po);
        end
        idle();
        @(posedge clk);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset_n = 1'b0;
        idle();
        test_reset();
        test_alu_write();
        test_round_robin();
        test_scoreboard();
        test_set_wins();
        test_load_only();
        test_alu_borrow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port and the carry/borrow flag update between two producers: the ALU result path and the memory-load path.
- Uses round-robin arbitration with valid/ready handshakes and drives registered write strobes into the 8x16 register file.
- Holds a pending-write scoreboard, per-register, so decode can stall on RAW hazards for its two source-register selects.

Parameters:
- NUM_REG, 8, number of architectural registers.
- REG_W, 3, register index width (log2 NUM_REG).
- DATA_W, 16, register data width.

Ports:
- clk_pi  in  1  system clock, rising edge.
- reset_n_pi  in  1  asynchronous, active-low reset.
- alu_valid_pi  in  1  ALU write request.
- alu_ready_po  out  1  ALU request accepted this cycle.
- alu_reg_pi  in  REG_W  ALU destination register.
- alu_data_pi  in  DATA_W  ALU result.
- alu_carry_we_pi  in  1  ALU request updates the carry flag.
- alu_carry_pi  in  1  new carry value.
- alu_borrow_we_pi  in  1  ALU request updates the borrow flag.
- alu_borrow_pi  in  1  new borrow value.
- mem_valid_pi  in  1  load write request.
- mem_ready_po  out  1  load request accepted this cycle.
- mem_reg_pi  in  REG_W  load destination register.
- mem_data_pi  in  DATA_W  load data.
- reserve_valid_pi  in  1  decode issues an instruction that will write reserve_reg_pi.
- reserve_reg_pi  in  REG_W  register to mark pending.
- source_reg1_pi  in  REG_W  decode source select 1.
- source_reg2_pi  in  REG_W  decode source select 2.
- src1_busy_po  out  1  source 1 has a write outstanding.
- src2_busy_po  out  1  source 2 has a write outstanding.
- wr_en_po  out  1  register file write strobe.
- wr_reg_po  out  REG_W  write index.
- wr_data_po  out  DATA_W  write data.
- carry_we_po  out  1  carry flag write strobe.
- carry_po  out  1  carry value.
- borrow_we_po  out  1  borrow flag write strobe.
- borrow_po  out  1  borrow value.
- pending_po  out  NUM_REG  scoreboard vector.

Behaviour:
- Clock and reset: one clock, clk_pi. reset_n_pi is asynchronous and active-low.
- Reset values:
  - All wr_* and *_we_po outputs, carry_po, borrow_po, wr_reg_po and wr_data_po are 0.
  - pending_po is all-zero.
  - last_grant = MEM, so the ALU wins the first tie.
- Reset mid-operation: a captured but not yet presented write is discarded, and scoreboard contents are lost.
- Arbitration (combinational, same cycle):
  - Only the ALU valid: alu_ready_po=1.
  - Only the load valid: mem_ready_po=1.
  - Both valid: grant the requester that is not last_grant.
  - Never both ready in one cycle. Ready is 0 when the requester's own valid is 0.
- Transfer occurs on valid && ready.
- last_grant updates only on a transfer.
- A non-granted requester must hold its valid and payload stable until it is accepted.
- Write latency: a transfer in cycle N produces wr_en_po=1 for exactly one cycle (N+1), carrying the captured reg and data.
  - Sustained throughput is one write per cycle.
  - Back-to-back transfers give consecutive write pulses.
- Flags:
  - ALU transfer: carry_we_po and borrow_we_po equal the captured alu_*_we_pi; carry_po and borrow_po equal the captured values.
  - Load transfer: both flag write-enables are 0 and the flag values are 0.
  - A flag write is independent of wr_en_po. The ALU may update flags and a register in the same pulse.
- Scoreboard:
  - pending[r] sets on reserve_valid_pi in the next cycle.
  - pending[r] clears in the cycle after a transfer to r, aligned with the wr_en_po pulse.
  - Reserve and clear to the same r in the same cycle: set wins, because a newer writer is in flight.
  - A write to a non-pending register is legal and leaves pending unchanged at 0.
  - No counting: a second reserve of an already-pending register leaves it pending, and one write clears it.
- Busy outputs:
  - src1_busy_po = pending[source_reg1_pi] and src2_busy_po = pending[source_reg2_pi], both combinational from registered state.
  - A clear is not bypassed: busy drops in the cycle wr_en_po is high.
- Same destination from both requesters in one cycle: only one is granted. The order follows round-robin and both writes occur, so the last accepted write wins in the register file.
- No internal queue beyond the one-stage output register. Backpressure comes only from arbitration loss, because the register file always accepts.

Decomposition:
- regfile_pkg holds:
  - NUM_REG, REG_W, DATA_W.
  - Requester enum req_id_t {REQ_ALU, REQ_MEM}.
  - A write-command struct (reg, data, carry_we, carry, borrow_we, borrow).
- One sub-module, rr_arbiter2:
  - 2-way round-robin grant with a last_grant register.
  - Inputs: req[1:0], advance.
  - Output: one-hot gnt[1:0].
- Scoreboard and output register stay in the top level.

Test Plan:
- Reset, then alu_valid_pi=1, alu_reg_pi=3, alu_data_pi=16'h00A5, alu_carry_we_pi=1, alu_carry_pi=1 -> alu_ready_po=1 same cycle. Next cycle: wr_en_po=1, wr_reg_po=3, wr_data_po=16'h00A5, carry_we_po=1, carry_po=1, borrow_we_po=0.
- Both valid for 4 cycles (ALU reg 1 data 16'h1111, load reg 2 data 16'h2222) -> grants ALU, MEM, ALU, MEM. wr_reg_po sequence 1, 2, 1, 2 on consecutive cycles. Never both ready.
- reserve_valid_pi=1, reserve_reg_pi=5; next cycle source_reg1_pi=5 -> src1_busy_po=1, pending_po=8'b0010_0000. Load write to reg 5 accepted -> busy falls in the wr_en_po cycle.
- Same cycle: reserve reg 5 and accepted write to reg 5 while pending -> pending[5] remains 1 afterward.
- Load-only write to reg 7 data 16'hFFFF -> wr_en_po=1, carry_we_po=0, borrow_we_po=0.
- reset_n_pi pulsed low in the cycle after an accepted ALU transfer -> wr_en_po=0 immediately (asynchronous), pending_po=0, and the next tie grants ALU first.
